bin2str_seq: RTL and testbench

BIN2STR_SEQ -- requirements
Module: bin2str_seq

---
 rtl/bin2str_seq.sv | 103 ++++++++++
 tb/tb_bin2str_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bin2str_seq.sv
// Sequential binary-to-ASCII-decimal converter (double dabble, one bit per cycle).
// Define BIN2STR_ZERO_BLANK_EN to render leading zeros as spaces.
module bin2str_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [DIGITS*8-1:0]   str,
  output logic                  overflow
);

  localparam int unsigned BCD_W = (DIGITS + 1) * 4;
  localparam int unsigned CW    = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t           state, state_nx;
  logic [BIN_W-1:0] op;
  logic [BCD_W-1:0] bcd, bcd_adj;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;

  function automatic logic [DIGITS*8-1:0] fmt(input logic [DIGITS*4-1:0] b);
    logic [DIGITS*8-1:0] s;
`ifdef BIN2STR_ZERO_BLANK_EN
    logic        lead;
    int unsigned i;
    s    = '0;
    lead = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      i = DIGITS - 1 - k;
      if (b[i*4 +: 4] != 4'd0 || i == 0) lead = 1'b0;
      s[i*8 +: 8] = lead ? 8'h20 : {4'h3, b[i*4 +: 4]};
    end
`else
    s = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      s[i*8 +: 8] = {4'h3, b[i*4 +: 4]};
    end
`endif
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned d = 0; d < DIGITS + 1; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == '0)   state_nx = OUT;
      OUT:     if (done_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == OUT);

  // A carry out of the top kept digit (into the guard) means the value no
  // longer fits; it is sticky because the prefix value only grows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      str      <= fmt('0);
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start_valid) begin
          op      <= bin;
          bcd     <= '0;
          cnt     <= CW'(BIN_W);
          ovf_acc <= 1'b0;
        end
        SHIFT: if (cnt != '0) begin
          {bcd, op} <= {bcd_adj[BCD_W-2:0], op, 1'b0};
          cnt       <= cnt - 1'b1;
          ovf_acc   <= ovf_acc | bcd_adj[DIGITS*4-1] | bcd_adj[BCD_W-1];
        end else begin
          str      <= fmt(bcd[DIGITS*4-1:0]);
          overflow <= ovf_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2str_seq.sv
// Directed bench for bin2str_seq: default instance plus a DIGITS=3 instance for truncation.
module tb_bin2str_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sv5 = 1'b0, dr5 = 1'b0, sv3 = 1'b0, dr3 = 1'b0;
  logic [13:0] bin5 = '0, bin3 = '0;
  logic        sr5, dv5, ov5, sr3, dv3, ov3;
  logic [39:0] str5;
  logic [23:0] str3;
  int          cmp = 0;
  int          errs = 0;

`ifdef BIN2STR_ZERO_BLANK_EN
  localparam logic [39:0] Z5   = 40'h2020202030;
  localparam logic [23:0] Z3   = 24'h202030;
  localparam logic [39:0] S907 = 40'h2020393037;
  localparam logic [39:0] S42  = 40'h2020203432;
  localparam logic [39:0] S7   = 40'h2020202037;
`else
  localparam logic [39:0] Z5   = 40'h3030303030;
  localparam logic [23:0] Z3   = 24'h303030;
  localparam logic [39:0] S907 = 40'h3030393037;
  localparam logic [39:0] S42  = 40'h3030303432;
  localparam logic [39:0] S7   = 40'h3030303037;
`endif
  localparam logic [39:0] S12345 = 40'h3132333435;
  localparam logic [39:0] S16383 = 40'h3136333833;

  always #5 clk = ~clk;

  bin2str_seq u_d5 (
    .clk(clk), .rst(rst), .start_valid(sv5), .start_ready(sr5), .bin(bin5),
    .done_valid(dv5), .done_ready(dr5), .str(str5), .overflow(ov5)
  );

  bin2str_seq #(.BIN_W(14), .DIGITS(3)) u_d3 (
    .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(sr3), .bin(bin3),
    .done_valid(dv3), .done_ready(dr3), .str(str3), .overflow(ov3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns edges from acceptance until done_valid is seen, or -1 on timeout.
  task automatic wait_done(input bit use3, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((use3 ? dv3 : dv5) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic conv5(input logic [13:0] v, output int n);
    sv5 = 1'b1; bin5 = v;
    tick();
    sv5 = 1'b0;
    wait_done(1'b0, n);
  endtask

  task automatic conv3(input logic [13:0] v, output int n);
    sv3 = 1'b1; bin3 = v;
    tick();
    sv3 = 1'b0;
    wait_done(1'b1, n);
  endtask

  task automatic release5();
    dr5 = 1'b1; tick(); dr5 = 1'b0;
  endtask

  task automatic release3();
    dr3 = 1'b1; tick(); dr3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cmp++; if (sr5 !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", sr5); end
    cmp++; if (dv5 !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", dv5); end
    cmp++; if (ov5 !== 1'b0) begin errs++; $display("FAIL reset_ovf got=%b exp=0", ov5); end
    cmp++; if (str5 !== Z5) begin errs++; $display("FAIL reset_str got=%h exp=%h", str5, Z5); end
    cmp++; if (str3 !== Z3) begin errs++; $display("FAIL reset_str3 got=%h exp=%h", str3, Z3); end
  endtask

  task automatic test_basic();
    int n;
    conv5(14'd12345, n);
    cmp++; if (n !== 15) begin errs++; $display("FAIL latency_12345 got=%0d exp=15", n); end
    cmp++; if (str5 !== S12345) begin errs++; $display("FAIL str_12345 got=%h exp=%h", str5, S12345); end
    cmp++; if (ov5 !== 1'b0) begin errs++; $display("FAIL ovf_12345 got=%b exp=0", ov5); end
    release5();
    conv5(14'd16383, n);
    cmp++; if (str5 !== S16383) begin errs++; $display("FAIL str_16383 got=%h exp=%h", str5, S16383); end
    cmp++; if (ov5 !== 1'b0) begin errs++; $display("FAIL ovf_16383 got=%b exp=0", ov5); end
    release5();
  endtask

  task automatic test_zero_blank();
    int n;
    conv5(14'd0, n);
    cmp++; if (n !== 15) begin errs++; $display("FAIL latency_zero got=%0d exp=15", n); end
    cmp++; if (str5 !== Z5) begin errs++; $display("FAIL str_zero got=%h exp=%h", str5, Z5); end
    release5();
    conv5(14'd907, n);
    cmp++; if (str5 !== S907) begin errs++; $display("FAIL str_907 got=%h exp=%h", str5, S907); end
    release5();
  endtask

  task automatic test_overflow();
    int n;
    conv3(14'd1234, n);
    cmp++; if (str3 !== 24'h323334) begin errs++; $display("FAIL str3_1234 got=%h exp=323334", str3); end
    cmp++; if (ov3 !== 1'b1) begin errs++; $display("FAIL ovf3_1234 got=%b exp=1", ov3); end
    release3();
    conv3(14'd999, n);
    cmp++; if (str3 !== 24'h393939) begin errs++; $display("FAIL str3_999 got=%h exp=393939", str3); end
    cmp++; if (ov3 !== 1'b0) begin errs++; $display("FAIL ovf3_999 got=%b exp=0", ov3); end
    release3();
    conv3(14'd1000, n);
    cmp++; if (str3 !== Z3) begin errs++; $display("FAIL str3_1000 got=%h exp=%h", str3, Z3); end
    cmp++; if (ov3 !== 1'b1) begin errs++; $display("FAIL ovf3_1000 got=%b exp=1", ov3); end
    release3();
  endtask

  task automatic test_reset_mid();
    int n;
    sv5 = 1'b1; bin5 = 14'd12345;
    tick();
    sv5 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    cmp++; if (sr5 !== 1'b1) begin errs++; $display("FAIL midrst_ready got=%b exp=1", sr5); end
    cmp++; if (dv5 !== 1'b0) begin errs++; $display("FAIL midrst_done got=%b exp=0", dv5); end
    cmp++; if (str5 !== Z5) begin errs++; $display("FAIL midrst_str got=%h exp=%h", str5, Z5); end
    conv5(14'd42, n);
    cmp++; if (n !== 15) begin errs++; $display("FAIL latency_42 got=%0d exp=15", n); end
    cmp++; if (str5 !== S42) begin errs++; $display("FAIL str_42 got=%h exp=%h", str5, S42); end
    release5();
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    conv5(14'd12345, n);
    bad = 0;
    dr5 = 1'b0; sv5 = 1'b1; bin5 = 14'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dv5 !== 1'b1 || str5 !== S12345 || sr5 !== 1'b0) bad++;
    end
    cmp++; if (bad !== 0) begin errs++; $display("FAIL hold_stable got=%0d bad cycles exp=0 (str=%h)", bad, str5); end
    dr5 = 1'b1; bin5 = 14'd7;
    tick();
    dr5 = 1'b0;
    cmp++; if (sr5 !== 1'b1) begin errs++; $display("FAIL b2b_idle_ready got=%b exp=1", sr5); end
    cmp++; if (dv5 !== 1'b0) begin errs++; $display("FAIL b2b_idle_done got=%b exp=0", dv5); end
    cmp++; if (str5 !== S12345) begin errs++; $display("FAIL b2b_str_hold got=%h exp=%h", str5, S12345); end
    tick();
    sv5 = 1'b0;
    cmp++; if (sr5 !== 1'b0) begin errs++; $display("FAIL b2b_accept got=%b exp=0", sr5); end
    wait_done(1'b0, n);
    cmp++; if (n !== 15) begin errs++; $display("FAIL b2b_latency got=%0d exp=15", n); end
    cmp++; if (str5 !== S7) begin errs++; $display("FAIL b2b_str7 got=%h exp=%h", str5, S7); end
    release5();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_blank();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
